// File: rtl/sram_2rw_array.sv
// sram_2rw_array
//   Parametrised two-port (2RW) synchronous SRAM behavioural macro. Both ports
//   share one clock and can read or write any word. Adds per-byte write
//   masks, a fixed collision policy (reads see old data, port 1 wins
//   overlapping write bytes), an optional output pipeline stage, read-valid
//   strobes and a post-reset sequencer that zeroes the array.
//
// Ports
//   CE            clock, rising edge, shared by both ports
//   RSTB          asynchronous active-low reset
//   CSB1/CSB2     chip select, active-low
//   WEB1/WEB2     write enable, active-low
//   OEB1/OEB2     read enable, active-low
//   A1/A2         word address
//   I1/I2         write data
//   M1/M2         per-byte write mask, active-high
//   O1/O2         read data (holds last value between reads)
//   V1/V2         one-cycle pulse marking new data on O1/O2
//   BUSY          high while the clear sequence runs; requests are dropped
module sram_2rw_array #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 5,
  parameter int DEPTH          = 32,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                CE,
  input  logic                RSTB,
  input  logic                CSB1,
  input  logic                CSB2,
  input  logic                WEB1,
  input  logic                WEB2,
  input  logic                OEB1,
  input  logic                OEB2,
  input  logic [ADDR_W-1:0]   A1,
  input  logic [ADDR_W-1:0]   A2,
  input  logic [DATA_W-1:0]   I1,
  input  logic [DATA_W-1:0]   I2,
  input  logic [DATA_W/8-1:0] M1,
  input  logic [DATA_W/8-1:0] M2,
  output logic [DATA_W-1:0]   O1,
  output logic [DATA_W-1:0]   O2,
  output logic                V1,
  output logic                V2,
  output logic                BUSY
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  localparam state_e           RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
  localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C      = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign BUSY = (state_q == ST_CLEAR);

  // --------------------------------------------------------------------------
  // Request decode: requests only count once the array is ready.
  // --------------------------------------------------------------------------
  logic ready;
  logic re1, re2, we1, we2;
  logic inr1, inr2;

  assign ready = (state_q == ST_READY);
  assign re1   = ready & ~CSB1 & ~OEB1;
  assign re2   = ready & ~CSB2 & ~OEB2;
  assign we1   = ready & ~CSB1 & ~WEB1;
  assign we2   = ready & ~CSB2 & ~WEB2;
  assign inr1  = ({1'b0, A1} < DEPTH_C);
  assign inr2  = ({1'b0, A2} < DEPTH_C);

  // --------------------------------------------------------------------------
  // Storage array
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset term; it models a RAM macro whose cells are
  // not resettable, and zeroing it is the job of the clear sequencer.
  always_ff @(posedge CE) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      // Port 2 is applied first so that, for a byte both ports write at the
      // same address, the later port-1 assignment is the one that sticks.
      for (int b = 0; b < NB; b++) begin
        if (we2 && inr2 && M2[b]) mem_q[A2][8*b +: 8] <= I2[8*b +: 8];
        if (we1 && inr1 && M1[b]) mem_q[A1][8*b +: 8] <= I1[8*b +: 8];
      end
    end
  end

  // Reads sample the array before this edge's writes land, so any same-cycle
  // write on either port is invisible to the read (old-data policy).
  logic [DATA_W-1:0] rd1, rd2;
  assign rd1 = inr1 ? mem_q[A1] : '0;
  assign rd2 = inr2 ? mem_q[A2] : '0;

  // --------------------------------------------------------------------------
  // Output path
  // --------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic              s_v1_q, s_v2_q;
    logic [DATA_W-1:0] s_d1_q, s_d2_q;

    always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
        s_v1_q <= 1'b0;
        s_v2_q <= 1'b0;
        s_d1_q <= '0;
        s_d2_q <= '0;
        V1     <= 1'b0;
        V2     <= 1'b0;
        O1     <= '0;
        O2     <= '0;
      end else begin
        s_v1_q <= re1;
        s_v2_q <= re2;
        if (re1) s_d1_q <= rd1;
        if (re2) s_d2_q <= rd2;
        V1 <= s_v1_q;
        V2 <= s_v2_q;
        if (s_v1_q) O1 <= s_d1_q;
        if (s_v2_q) O2 <= s_d2_q;
      end
    end
  end else begin : g_out_direct
    always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
        V1 <= 1'b0;
        V2 <= 1'b0;
        O1 <= '0;
        O2 <= '0;
      end else begin
        V1 <= re1;
        V2 <= re2;
        if (re1) O1 <= rd1;
        if (re2) O2 <= rd2;
      end
    end
  end

endmodule

// File: tb/tb_sram_2rw_array.sv
// tb_sram_2rw_array
//   Drives two instances of sram_2rw_array with identical port traffic:
//   instance 0 is 16x32 with direct outputs, instance 1 is 16x24 with the
//   output register. A behavioural model (word arrays, a busy countdown and a
//   history of read results delayed by each instance's latency) predicts
//   O/V/BUSY after every clock edge. Directed sequences reproduce the key
//   scenarios with literal expected values, followed by random traffic.
module tb_sram_2rw_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb;
  logic        csb [2];
  logic        web [2];
  logic        oeb [2];
  logic [4:0]  a   [2];
  logic [15:0] din [2];
  logic [1:0]  msk [2];

  logic [15:0] o_w    [2][2];
  logic        v_w    [2][2];
  logic        busy_w [2];

  sram_2rw_array #(
    .DATA_W(16), .ADDR_W(5), .DEPTH(32), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) u_dut32 (
    .CE(clk), .RSTB(rstb),
    .CSB1(csb[0]), .CSB2(csb[1]), .WEB1(web[0]), .WEB2(web[1]),
    .OEB1(oeb[0]), .OEB2(oeb[1]), .A1(a[0]), .A2(a[1]),
    .I1(din[0]), .I2(din[1]), .M1(msk[0]), .M2(msk[1]),
    .O1(o_w[0][0]), .O2(o_w[0][1]), .V1(v_w[0][0]), .V2(v_w[0][1]),
    .BUSY(busy_w[0])
  );

  sram_2rw_array #(
    .DATA_W(16), .ADDR_W(5), .DEPTH(24), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) u_dut24 (
    .CE(clk), .RSTB(rstb),
    .CSB1(csb[0]), .CSB2(csb[1]), .WEB1(web[0]), .WEB2(web[1]),
    .OEB1(oeb[0]), .OEB2(oeb[1]), .A1(a[0]), .A2(a[1]),
    .I1(din[0]), .I2(din[1]), .M1(msk[0]), .M2(msk[1]),
    .O1(o_w[1][0]), .O2(o_w[1][1]), .V1(v_w[1][0]), .V2(v_w[1][1]),
    .BUSY(busy_w[1])
  );

  // Reference model state
  int          depth_m [2] = '{32, 24};
  int          lat_m   [2] = '{1, 2};
  logic [15:0] mem_m   [2][32];
  int          busy_m  [2];
  logic        hv      [2][2][4];
  logic [15:0] hd      [2][2][4];
  logic [15:0] eo      [2][2];
  logic        ev      [2][2];
  int          cyc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy_m[k] = depth_m[k];
      for (int w = 0; w < 32; w++) mem_m[k][w] = 16'h0;
      for (int p = 0; p < 2; p++) begin
        eo[k][p] = 16'h0;
        ev[k][p] = 1'b0;
        for (int s = 0; s < 4; s++) begin
          hv[k][p][s] = 1'b0;
          hd[k][p][s] = 16'h0;
        end
      end
    end
    cyc = 0;
  endtask

  // Effect of one rising edge on the model, using the inputs currently driven.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic        rv [2];
      logic [15:0] rd [2];
      int          s;
      rv[0] = 1'b0; rv[1] = 1'b0;
      rd[0] = 16'h0; rd[1] = 16'h0;
      if (busy_m[k] > 0) begin
        busy_m[k]--;
      end else begin
        // Reads observe the word as it was before this edge.
        for (int p = 0; p < 2; p++) begin
          rv[p] = !csb[p] && !oeb[p];
          rd[p] = (a[p] < depth_m[k]) ? mem_m[k][a[p]] : 16'h0;
        end
        // Byte rule: a byte takes port 1's data if port 1 writes it,
        // otherwise port 2's data if port 2 writes it.
        for (int b = 0; b < 2; b++) begin
          if (!csb[1] && !web[1] && a[1] < depth_m[k] && msk[1][b])
            mem_m[k][a[1]][8*b +: 8] = din[1][8*b +: 8];
          if (!csb[0] && !web[0] && a[0] < depth_m[k] && msk[0][b])
            mem_m[k][a[0]][8*b +: 8] = din[0][8*b +: 8];
        end
      end
      s = (cyc + 5 - lat_m[k]) % 4;
      for (int p = 0; p < 2; p++) begin
        hv[k][p][cyc % 4] = rv[p];
        hd[k][p][cyc % 4] = rd[p];
      end
      for (int p = 0; p < 2; p++) begin
        if (hv[k][p][s]) begin
          eo[k][p] = hd[k][p][s];
          ev[k][p] = 1'b1;
        end else begin
          ev[k][p] = 1'b0;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("O%0d_d%0d", p + 1, depth_m[k]), o_w[k][p], eo[k][p]);
        check($sformatf("V%0d_d%0d", p + 1, depth_m[k]), v_w[k][p], ev[k][p]);
      end
      check($sformatf("BUSY_d%0d", depth_m[k]), busy_w[k], busy_m[k] > 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      csb[p] = 1'b1; web[p] = 1'b1; oeb[p] = 1'b1; msk[p] = 2'b00;
    end
  endtask

  task automatic set_wr(input int p, input logic [4:0] ad, input logic [15:0] d, input logic [1:0] m);
    csb[p] = 1'b0; web[p] = 1'b0; oeb[p] = 1'b1;
    a[p] = ad; din[p] = d; msk[p] = m;
  endtask

  task automatic set_rd(input int p, input logic [4:0] ad);
    csb[p] = 1'b0; web[p] = 1'b1; oeb[p] = 1'b0; a[p] = ad;
  endtask

  // Called just after a rising edge; asserts reset across one edge and
  // releases it before the next edge, which becomes clear cycle 1.
  task automatic apply_reset();
    #1 rstb = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    #2 rstb = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_edges;
    rstb = 1'b0;
    idle();
    for (int p = 0; p < 2; p++) begin
      a[p] = '0; din[p] = '0;
    end
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Clear length after reset release
    busy_edges = 0;
    for (int n = 0; n < 40 && busy_w[0]; n++) begin
      cycle();
      busy_edges++;
    end
    check("clear_len", busy_edges, 32);

    // Every address reads back zero, valid one edge after the request
    for (int ad = 0; ad < 32; ad++) begin
      set_rd(0, 5'(ad));
      cycle();
      check("sweep_o", o_w[0][0], 16'h0000);
      check("sweep_v", v_w[0][0], 1'b1);
    end
    idle(); cycle();

    // Byte mask
    set_wr(0, 5'd3, 16'hABCD, 2'b11); cycle();
    set_wr(0, 5'd3, 16'h1234, 2'b01); cycle();
    set_rd(0, 5'd3); cycle();
    check("mask_o_d32", o_w[0][0], 16'hAB34);
    idle(); cycle();
    check("mask_o_d24", o_w[1][0], 16'hAB34);
    check("mask_v_d24", v_w[1][0], 1'b1);

    // Write-write collision, then cross-port read-during-write
    set_wr(0, 5'd7, 16'h1111, 2'b01);
    set_wr(1, 5'd7, 16'h2222, 2'b11);
    cycle();
    idle(); set_rd(0, 5'd7); cycle();
    check("coll_o_d32", o_w[0][0], 16'h2211);
    idle();
    set_rd(1, 5'd7);
    set_wr(0, 5'd7, 16'h5555, 2'b11);
    cycle();
    check("xrdw_o2_d32", o_w[0][1], 16'h2211);
    idle(); cycle();
    check("xrdw_o2_d24", o_w[1][1], 16'h2211);
    set_rd(0, 5'd7); cycle();
    check("xrdw_after_d32", o_w[0][0], 16'h5555);
    idle(); cycle();

    // Output-register latency with back-to-back reads
    set_wr(0, 5'd0, 16'h000A, 2'b11);
    set_wr(1, 5'd1, 16'h000B, 2'b11);
    cycle();
    idle(); set_wr(0, 5'd2, 16'h000C, 2'b11); cycle();
    idle(); cycle();
    for (int e = 0; e < 5; e++) begin
      idle();
      if (e < 3) set_rd(0, 5'(e));
      cycle();
      check($sformatf("oreg_v_e%0d", e + 1), v_w[1][0], (e >= 1 && e <= 3));
      if (e >= 1 && e <= 3) check($sformatf("oreg_o_e%0d", e + 1), o_w[1][0], 16'h000A + 16'(e - 1));
    end

    // Out-of-range address on the 24-word instance
    set_wr(0, 5'd30, 16'hFFFF, 2'b11); cycle();
    idle(); set_rd(0, 5'd30); cycle();
    check("oor_o_d32", o_w[0][0], 16'hFFFF);
    idle(); cycle();
    check("oor_o_d24", o_w[1][0], 16'h0000);
    check("oor_v_d24", v_w[1][0], 1'b1);
    for (int ad = 0; ad < 24; ad++) begin
      idle(); set_rd(1, 5'(ad)); cycle();
    end
    idle(); cycle();

    // Reset in the middle of the clear sequence
    set_wr(0, 5'd9, 16'h7777, 2'b11); cycle();
    idle(); cycle();
    apply_reset();
    for (int n = 0; n < 10; n++) cycle();
    apply_reset();
    busy_edges = 0;
    for (int n = 1; n <= 40 && busy_w[0]; n++) begin
      idle();
      if (n == 5) set_wr(0, 5'd9, 16'hBEEF, 2'b11);
      cycle();
      busy_edges++;
    end
    check("reclear_len", busy_edges, 32);
    idle(); set_rd(0, 5'd9); cycle();
    check("drop_o_d32", o_w[0][0], 16'h0000);
    check("drop_v_d32", v_w[0][0], 1'b1);
    idle(); cycle();

    // Random traffic, with a reset landing on an in-flight read
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        csb[p] = ($urandom_range(0, 3) == 0);
        web[p] = 1'($urandom_range(0, 1));
        oeb[p] = 1'($urandom_range(0, 1));
        a[p]   = 5'($urandom_range(0, 31));
        din[p] = 16'($urandom);
        msk[p] = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) a[1] = a[0];
      if (i == 200) begin
        idle();
        set_rd(0, 5'($urandom_range(0, 23)));
        set_rd(1, 5'($urandom_range(0, 23)));
        cycle();
        idle();
        apply_reset();
      end else begin
        cycle();
      end
    end
    idle(); cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_2rw_array.md
Name: sram_2rw_array

Overview:
- Parametrised two-port (2RW) synchronous SRAM behavioural macro for the tech SRAM set; generalises the fixed 32x8 dual-port model.
- Adds per-byte write masks, a defined collision policy, an optional output pipeline register, read-valid strobes and a post-reset memory clear sequencer.
- Single clock shared by both ports; instantiated by SRAM wrappers in simulation and in pre-macro synthesis.

Parameters:
- DATA_W, 8, data width per port; must be a multiple of 8.
- ADDR_W, 5, address width.
- DEPTH, 32, number of words; must satisfy DEPTH <= 2**ADDR_W.
- OUT_REG, 0, 1 adds an output pipeline stage (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1, 1 zeroes the whole array after reset deassertion.

Ports:
- CE  in  1  clock, rising edge, shared by both ports.
- RSTB  in  1  reset, asynchronous, active-low.
- CSB1/CSB2  in  1  port chip select, active-low.
- WEB1/WEB2  in  1  port write enable, active-low.
- OEB1/OEB2  in  1  port read enable, active-low.
- A1/A2  in  ADDR_W  port address.
- I1/I2  in  DATA_W  port write data.
- M1/M2  in  DATA_W/8  per-byte write mask, active-high (1 = write this byte).
- O1/O2  out  DATA_W  port read data.
- V1/V2  out  1  read-data valid, one-cycle pulse aligned with new O data.
- BUSY  out  1  high while the clear sequence runs; all port requests are ignored while high.

Behaviour:
- Reset (RSTB low, asynchronous): O1/O2 = 0, V1/V2 = 0, pipeline stages cleared, clear counter = 0. BUSY = 1 when CLEAR_ON_RESET = 1, else BUSY = 0. Array contents are not reset directly.
- FSM states: CLEAR and READY.
  - Reset enters CLEAR if CLEAR_ON_RESET = 1, else READY.
  - CLEAR writes 0 to word[cnt] on each CE edge and increments cnt.
  - After the write of word DEPTH-1, the FSM moves to READY and BUSY drops on that same edge. Clear therefore takes exactly DEPTH cycles after RSTB rises.
  - Reset asserted mid-clear restarts the sequence from cnt = 0.
- Enables: RE = ~CSB & ~OEB; WE = ~CSB & ~WEB. Both enables are sampled on the rising CE edge and are evaluated only in READY.
- Read latency:
  - OUT_REG = 0: O updates on the edge that samples RE, and V pulses high for that cycle.
  - OUT_REG = 1: O and V appear one edge later.
  - Back-to-back reads are accepted every cycle.
  - O holds its last value when no read is issued; V is 0 on any cycle without new data.
- Write: on a CE edge with WE, byte b of word[A] takes I[8b+7:8b] only where M[b] = 1. A mask of all zeros is a no-op.
- Read-during-write, same port, same address: read returns the pre-write (old) word.
- Cross-port, read on one port and write to the same address on the other in the same cycle: the read returns the old word.
- Write-write collision, same address: for bytes with both mask bits set, port 1 wins. Non-overlapping masked bytes from both ports are applied.
- Out-of-range address (A >= DEPTH): writes are ignored; reads return 0 with V still pulsed.
- Requests arriving while BUSY = 1 are dropped: no write, V stays 0, O unchanged.
- Reset during an in-flight OUT_REG read: the pending data is discarded and V does not pulse.

Test Plan:
- CLEAR_ON_RESET = 1, DEPTH = 32, DATA_W = 16:
  - Stimulus: release RSTB, then sample BUSY.
  - Required: BUSY stays high for exactly 32 CE edges. A subsequent read of every address returns 0x0000 with V1 = 1 one cycle after each request.
- Byte mask:
  - Stimulus: write 0xABCD to A1 = 3 with M1 = 2'b11, then write 0x1234 to address 3 with M1 = 2'b01, then read address 3.
  - Required: O1 = 0xAB34.
- Collision:
  - Stimulus: port 1 writes 0x1111 and port 2 writes 0x2222, both to address 7, with M1 = 2'b01 and M2 = 2'b11; then read address 7.
  - Required: word = 0x2211.
  - Stimulus: in the same cycle, port 2 reads address 7 while port 1 writes 0x5555 to address 7.
  - Required: O2 = 0x2211.
- OUT_REG = 1:
  - Stimulus: reads of addresses 0, 1, 2 on consecutive cycles, holding pre-written values 0x0A, 0x0B, 0x0C.
  - Required: O1 = 0x0A, 0x0B, 0x0C on edges 2, 3, 4 after the first request; V1 is high on exactly those three cycles.
- Reset mid-clear:
  - Stimulus: assert RSTB low at clear cycle 10, then release.
  - Required: BUSY stays high for a full 32 cycles after release. A write issued at cycle 5 after release is dropped, and reading that address afterwards returns 0.
- DEPTH = 24, ADDR_W = 5:
  - Stimulus: write 0xFFFF to address 30, then read address 30.
  - Required: O = 0x0000 and V = 1; words 0–23 are unchanged.
